// File: rtl/rf_eu_seq.sv
// Register-file to execution-unit sequencer: streams operand vectors from the RF RAM into the EU,
// then writes the EU results back to the RF RAM, once per iteration, for cmd_len iterations.
module rf_eu_seq #(
    parameter int INPUT_NUM  = 1,
    parameter int OUTPUT_NUM = 1,
    parameter int DATA_W     = 1408,
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_src_addr,
    input  logic [ADDR_W-1:0]     cmd_dst_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  ram_re,
    output logic [ADDR_W-1:0]     ram_raddr,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_waddr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W-1:0]     eu_input_data,
    output logic [INPUT_NUM-1:0]  eu_input_we,
    output logic [OUTPUT_NUM-1:0] eu_output_re,
    input  logic [DATA_W-1:0]     eu_output_data,
    output logic                  busy,
    output logic                  done
);

    localparam int KW = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
    localparam int JW = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;
    localparam logic [KW-1:0]         K_LAST  = KW'(INPUT_NUM - 1);
    localparam logic [JW-1:0]         J_LAST  = JW'(OUTPUT_NUM - 1);
    localparam logic [INPUT_NUM-1:0]  IN_ONE  = INPUT_NUM'(1);
    localparam logic [OUTPUT_NUM-1:0] OUT_ONE = OUTPUT_NUM'(1);

    typedef enum logic [2:0] {IDLE, RD, LD, OUT, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q, i_q;
    logic [KW-1:0]     k_q;
    logic [JW-1:0]     j_q;

    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic              k_last, j_last, i_last;

    // Address arithmetic deliberately truncates to ADDR_W so base+offset wraps silently.
    assign rd_addr = src_q + ADDR_W'(32'(i_q) * 32'(INPUT_NUM)) + ADDR_W'(k_q);
    assign wr_addr = dst_q + ADDR_W'(32'(i_q) * 32'(OUTPUT_NUM)) + ADDR_W'(j_q);
    assign k_last  = (k_q == K_LAST);
    assign j_last  = (j_q == J_LAST);
    assign i_last  = (i_q == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            i_q       <= '0;
            k_q       <= '0;
            j_q       <= '0;
            // NOTE: ram_wdata is a visible output, so it is reset like any other state register.
            ram_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    src_q <= cmd_src_addr;
                    dst_q <= cmd_dst_addr;
                    len_q <= cmd_len;
                    i_q   <= '0;
                    k_q   <= '0;
                    j_q   <= '0;
                end
                LD:  if (!k_last) k_q <= k_q + KW'(1);
                OUT: ram_wdata <= eu_output_data;
                WR: begin
                    if (!j_last) begin
                        j_q <= j_q + JW'(1);
                    end else if (!i_last) begin
                        i_q <= i_q + LEN_W'(1);
                        k_q <= '0;
                        j_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        cmd_ready     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        ram_re        = 1'b0;
        ram_raddr     = '0;
        ram_we        = 1'b0;
        ram_waddr     = '0;
        eu_input_data = '0;
        eu_input_we   = '0;
        eu_output_re  = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_d = (cmd_len == '0) ? DONE : RD;
            end
            RD: begin
                ram_re    = 1'b1;
                ram_raddr = rd_addr;
                state_d   = LD;
            end
            LD: begin
                eu_input_data = ram_rdata;
                eu_input_we   = IN_ONE << k_q;
                state_d       = k_last ? OUT : RD;
            end
            OUT: begin
                eu_output_re = OUT_ONE << j_q;
                state_d      = WR;
            end
            WR: begin
                ram_we    = 1'b1;
                ram_waddr = wr_addr;
                if (!j_last)      state_d = OUT;
                else if (!i_last) state_d = RD;
                else              state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/rf_eu_seq.md
RF_EU_SEQ -- requirements
Module: rf_eu_seq

Interface
REQ-001 SHALL have parameter INPUT_NUM, default 1, number of EU operand write strobes per iteration.
REQ-002 SHALL have parameter OUTPUT_NUM, default 1, number of EU result read strobes per iteration.
REQ-003 SHALL have parameter DATA_W, default 1408 (176*8), vector width in bits.
REQ-004 SHALL have parameter ADDR_W, default 10, RF RAM address width.
REQ-005 SHALL have parameter LEN_W, default 10, iteration count width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port cmd_valid, input, 1, command offered.
REQ-010 SHALL have port cmd_ready, output, 1, sequencer can accept a command.
REQ-011 SHALL have port cmd_src_addr, input, ADDR_W, operand base address.
REQ-012 SHALL have port cmd_dst_addr, input, ADDR_W, result base address.
REQ-013 SHALL have port cmd_len, input, LEN_W, iteration count.
REQ-014 SHALL have port ram_re, output, 1, RF RAM read enable.
REQ-015 SHALL have port ram_raddr, output, ADDR_W, RF RAM read address.
REQ-016 SHALL have port ram_rdata, input, DATA_W, read data, valid one cycle after ram_re.
REQ-017 SHALL have port ram_we, output, 1, RF RAM write enable.
REQ-018 SHALL have port ram_waddr, output, ADDR_W, RF RAM write address.
REQ-019 SHALL have port ram_wdata, output, DATA_W, RF RAM write data.
REQ-020 SHALL have port eu_input_data, output, DATA_W, operand to EU.
REQ-021 SHALL have port eu_input_we, output, INPUT_NUM, one-hot operand strobe.
REQ-022 SHALL have port eu_output_re, output, OUTPUT_NUM, one-hot result strobe.
REQ-023 SHALL have port eu_output_data, input, DATA_W, EU result, valid in the cycle its eu_output_re bit is high.
REQ-024 SHALL have port busy, output, 1, command in progress.
REQ-025 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-026 SHALL implement FSM states IDLE, RD, LD, OUT, WR, DONE.
REQ-027 SHALL drive cmd_ready high only in IDLE; a command is accepted on a clk edge with cmd_valid and cmd_ready both high, and src, dst and len are latched.
REQ-028 SHALL transition on accept: to DONE if len==0, else to RD with iteration i=0, operand k=0 and result j=0.
REQ-029 In RD, SHALL assert ram_re with ram_raddr = src + i*INPUT_NUM + k, then go to LD.
REQ-030 In LD, SHALL drive eu_input_data = ram_rdata and eu_input_we bit k high; if k<INPUT_NUM-1 then k++ and go to RD, else go to OUT.
REQ-031 In OUT, SHALL assert eu_output_re bit j and register eu_output_data into ram_wdata at the cycle's closing edge, then go to WR.
REQ-032 In WR, SHALL assert ram_we with ram_waddr = dst + i*OUTPUT_NUM + j; if j<OUTPUT_NUM-1 then j++ and go to OUT; else if i<len-1 then i++, k=0, j=0 and go to RD; else go to DONE.
REQ-033 In DONE, SHALL pulse done high for one cycle and then return to IDLE.
REQ-034 SHALL compute all addresses modulo 2^ADDR_W, so wrap-around is silent.
REQ-035 SHALL make each iteration take exactly 2*INPUT_NUM + 2*OUTPUT_NUM cycles; done is high in cycle len*(2*INPUT_NUM+2*OUTPUT_NUM)+1 after the accept edge.
REQ-036 SHALL drive busy high in every state except IDLE; cmd_valid while busy is ignored.
REQ-037 SHALL hold eu_input_data at 0 outside LD; at most one strobe among ram_re, ram_we, eu_input_we and eu_output_re is high in any cycle.

Reset
REQ-038 On rst_n low, even mid-command, SHALL return immediately to IDLE with busy, done, ram_re, ram_we, eu_input_we and eu_output_re at 0, all addresses and ram_wdata at 0, and cmd_ready high once rst_n is released; no pending write completes.

Verification
REQ-039 INPUT_NUM=2, OUTPUT_NUM=1, src=0x010, dst=0x200, len=3 -> reads 0x010..0x015 in order, eu_input_we alternates 01/10, writes to 0x200..0x202 carry the captured EU results, done in cycle 19.
REQ-040 len=0 -> done in cycle 1 after accept; no ram or EU strobes.
REQ-041 src=0x3FF, INPUT_NUM=2, len=1 -> reads 0x3FF then 0x000.
REQ-042 cmd_valid held high during a command -> second command accepted on the first edge where cmd_ready is high again (cycle after done); the first command's writes are unaffected.
REQ-043 rst_n asserted during WR -> ram_we low immediately, FSM in IDLE, no write occurs.
